// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter. It serialises DATA_W-bit L/R pairs MSB-first with a one-bit delay into 64-bit frames.
// Latency: a pair accepted at cycle t is loaded at the first frame load after t. SCLK is clk/(2*SCLK_HALF). A frame lasts 128*SCLK_HALF cycles.
// Backpressure: a 2-pair FIFO drives the registered sample_ready low when it is full. An empty FIFO at frame load raises underrun.
//
// Ports:
//   clk, reset_n               system clock; synchronous active-low reset
//   sample_l/_r, sample_valid  producer pair; accepted when sample_valid && sample_ready
//   sample_ready               registered; high while the FIFO holds fewer than 2 pairs
//   I2S_SCLK/LRCLK/DOUT        codec bit clock, word select (0 = left), serial data
//   frame_start, underrun      one-cycle pulses on each frame load / on a load from an empty FIFO
// Build option: I2S_TX_UNDERRUN_HOLD_EN. When defined, an underrun repeats the last popped pair instead of sending silence.
module i2s_tx #(
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              I2S_SCLK,
  output logic              I2S_LRCLK,
  output logic              I2S_DOUT,
  output logic              frame_start,
  output logic              underrun
);
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  // Places a sample in a 32-slot half frame: slot 0 is empty (one-bit delay), the MSB goes in slot 1, and the pad bits are zero.
  function automatic logic [31:0] place(input logic [DATA_W-1:0] s);
    return {{(32-DATA_W){1'b0}}, s} << (31 - DATA_W);
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             dout_q, dout_d;
  logic [63:0]      shreg_q, shreg_d;
  pair_t            fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic             fs_q, fs_d, ur_q, ur_d;

  logic             sclk_fall, load, push, pop;
  pair_t            in_pair, fill_pair, load_pair;
  logic [63:0]      frame;

  assign in_pair = '{l: sample_l, r: sample_r};

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  pair_t held_q, held_d;
  assign held_d    = pop ? fifo0_q : held_q;
  assign fill_pair = held_q;
  always_ff @(posedge clk) begin
    if (!reset_n) held_q <= '0;
    else          held_q <= held_d;
  end
`else
  assign fill_pair = '0;
`endif

  always_comb begin
    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    dout_d    = dout_q;
    shreg_d   = shreg_q;
    fifo0_d   = fifo0_q;
    fifo1_d   = fifo1_q;
    fs_d      = 1'b0;
    ur_d      = 1'b0;
    load_pair = '0;
    frame     = '0;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    sclk_fall = (div_q == DIV_LAST) && sclk_q;
    load      = sclk_fall && (bit_cnt_q == 6'd63);
    push      = sample_valid && ready_q;
    // An empty FIFO cannot be popped at the load, even when a push lands in the same cycle.
    pop       = load && (count_q != 2'd0);

    if (sclk_fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (load) begin
        load_pair = pop ? fifo0_q : fill_pair;
        frame     = {place(load_pair.l), place(load_pair.r)};
        dout_d    = frame[63];
        shreg_d   = {frame[62:0], 1'b0};
        fs_d      = 1'b1;
        ur_d      = !pop;
      end else begin
        dout_d  = shreg_q[63];
        shreg_d = {shreg_q[62:0], 1'b0};
      end
    end

    // The FIFO is full only at count 2, and sample_ready is low then. So a push during a pop always finds count 1.
    if (pop) begin
      fifo0_d = push ? in_pair : fifo1_q;
    end else if (push) begin
      if (count_q == 2'd0) fifo0_d = in_pair;
      else                 fifo1_d = in_pair;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      lrclk_q   <= 1'b0;
      dout_q    <= 1'b0;
      shreg_q   <= '0;
      fifo0_q   <= '0;
      fifo1_q   <= '0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      dout_q    <= dout_d;
      shreg_q   <= shreg_d;
      fifo0_q   <= fifo0_d;
      fifo1_q   <= fifo1_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
    end
  end

  assign sample_ready = ready_q;
  assign I2S_SCLK     = sclk_q;
  assign I2S_LRCLK    = lrclk_q;
  assign I2S_DOUT     = dout_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx. Expected outputs come from a frame-level model:
// SCLK phase and bit slot are computed arithmetically from the cycle number, and the FIFO is a queue.
`timescale 1ns/1ps
module tb_i2s_tx;
  localparam int W     = 16;
  localparam int H     = 8;
  localparam int FIRST = 2 * H;     // first frame load cycle
  localparam int FRAME = 128 * H;   // cycles per frame

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, I2S_SCLK, I2S_LRCLK, I2S_DOUT, frame_start, underrun;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(W), .SCLK_HALF(H)) dut (
    .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .I2S_SCLK(I2S_SCLK),
    .I2S_LRCLK(I2S_LRCLK), .I2S_DOUT(I2S_DOUT), .frame_start(frame_start), .underrun(underrun)
  );

  typedef struct { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
  typedef struct { int cyc; bit vld; logic [W-1:0] l; logic [W-1:0] r; logic [5:0] exp; } vec_t;

  pair_t mq[$];        // model FIFO contents
  pair_t cap_q[$];     // frames captured from DOUT
  pair_t cur, last, cap_cur;
  vec_t  tbl[$];
  int    cyc;
  bit    m_ready, m_fs, m_ur, dut_push;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [5:0] dut_out();
    return {I2S_SCLK, I2S_LRCLK, I2S_DOUT, frame_start, underrun, sample_ready};
  endfunction

  function automatic logic [5:0] expected();
    logic sclk, lr, d;
    int t, b;
    sclk = 1'b0; lr = 1'b0; d = 1'b0;
    if (cyc > 0) begin
      sclk = ((cyc / H) % 2) == 1;
      if (cyc >= FIRST) begin
        t  = (cyc - FIRST) % FRAME;
        b  = t / (2 * H);
        lr = (b >= 32);
        if (b >= 1 && b <= W)              d = cur.l[W-b];
        else if (b >= 33 && b <= 32 + W)   d = cur.r[W-b+32];
      end
    end
    return {sclk, lr, d, m_fs, m_ur, m_ready};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got={sclk,lr,dout,fs,ur,rdy}=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // One clock: update the model with the pre-edge inputs, then compare every output.
  task automatic step();
    pair_t p;
    bit    load;
    int    b;
    dut_push = sample_valid && sample_ready;
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
      cyc = 0; m_ready = 0; m_fs = 0; m_ur = 0;
      cur.l = '0; cur.r = '0; last.l = '0; last.r = '0;
    end else begin
      cyc++;
      load = (cyc >= FIRST) && (((cyc - FIRST) % FRAME) == 0);
      m_fs = load;
      m_ur = load && (mq.size() == 0);
      if (load) begin
        if (mq.size() > 0) begin
          p = mq.pop_front(); cur = p; last = p;
        end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          cur = last;
`else
          cur.l = '0; cur.r = '0;
`endif
        end
      end
      if (sample_valid && m_ready) begin
        p.l = sample_l; p.r = sample_r;
        mq.push_back(p);
      end
      m_ready = (mq.size() < 2);
    end
    #1;
    check_vec("outputs", dut_out(), expected());
    if (cyc >= FIRST && ((cyc - FIRST) % (2 * H)) == 0) begin
      b = ((cyc - FIRST) % FRAME) / (2 * H);
      if (b == 0) begin cap_cur.l = '0; cap_cur.r = '0; end
      else if (b >= 1 && b <= W)            cap_cur.l[W-b]    = I2S_DOUT;
      else if (b >= 33 && b <= 32 + W)      cap_cur.r[W-b+32] = I2S_DOUT;
      else if (b == 63)                     cap_q.push_back(cap_cur);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (n) step();
    cap_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic push_at(input int c, input logic [W-1:0] l, input logic [W-1:0] r);
    run_to(c - 1);
    sample_valid = 1'b1; sample_l = l; sample_r = r;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic add_vec(input int c, input bit v, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [5:0] e);
    vec_t x;
    x.cyc = c; x.vld = v; x.l = l; x.r = r; x.exp = e;
    tbl.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, urc, ones1, ones2;
    logic [W-1:0] k;

    // Expected vector bits: {sclk, lrclk, dout, frame_start, underrun, sample_ready}
    add_vec(1,    0, 16'h0000, 16'h0000, 6'b000001);
    add_vec(2,    1, 16'hA5C3, 16'h0F01, 6'b000001);
    add_vec(8,    0, 16'h0000, 16'h0000, 6'b100001);
    add_vec(16,   0, 16'h0000, 16'h0000, 6'b000101);
    add_vec(17,   0, 16'h0000, 16'h0000, 6'b000001);
    add_vec(24,   0, 16'h0000, 16'h0000, 6'b100001);
    add_vec(32,   0, 16'h0000, 16'h0000, 6'b001001);
    add_vec(40,   0, 16'h0000, 16'h0000, 6'b101001);
    add_vec(48,   0, 16'h0000, 16'h0000, 6'b000001);
    add_vec(64,   0, 16'h0000, 16'h0000, 6'b001001);
    add_vec(272,  0, 16'h0000, 16'h0000, 6'b001001);
    add_vec(288,  0, 16'h0000, 16'h0000, 6'b000001);
    add_vec(512,  0, 16'h0000, 16'h0000, 6'b000001);
    add_vec(528,  0, 16'h0000, 16'h0000, 6'b010001);
    add_vec(544,  0, 16'h0000, 16'h0000, 6'b010001);
    add_vec(608,  0, 16'h0000, 16'h0000, 6'b011001);
    add_vec(784,  0, 16'h0000, 16'h0000, 6'b011001);
    add_vec(800,  0, 16'h0000, 16'h0000, 6'b010001);
    add_vec(1039, 0, 16'h0000, 16'h0000, 6'b110001);
    add_vec(1040, 0, 16'h0000, 16'h0000, 6'b000111);

    // Single pair A5C3/0F01 pushed at cycle 2, checked against the table.
    do_reset(3);
    for (int i = 0; i < tbl.size(); i++) begin
      run_to(tbl[i].cyc - 1);
      sample_valid = tbl[i].vld; sample_l = tbl[i].l; sample_r = tbl[i].r;
      step();
      sample_valid = 1'b0;
      check_vec($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    check("a5c3_frame_l", int'(cap_q.size() > 0 ? cap_q[0].l : 16'h0), 16'hA5C3);
    check("a5c3_frame_r", int'(cap_q.size() > 0 ? cap_q[0].r : 16'h0), 16'h0F01);

    // Continuous valid with incrementing pairs: 2 accepts up front, then one per frame.
    do_reset(2);
    k = '0; acc = 0;
    sample_valid = 1'b1; sample_l = 16'h1000; sample_r = 16'h2000;
    while (cyc < FIRST + 4 * FRAME + 10) begin
      step();
      if (dut_push) begin
        acc++; k++;
        sample_l = 16'h1000 + k; sample_r = 16'h2000 + k;
      end
      if (cyc == 12) check("accepts_before_load", acc, 2);
    end
    sample_valid = 1'b0;
    check("accepts_total", acc, 7);
    check("stream_frames", cap_q.size(), 4);
    for (int i = 0; i < cap_q.size(); i++) begin
      check($sformatf("stream_l%0d", i), int'(cap_q[i].l), 16'h1000 + i);
      check($sformatf("stream_r%0d", i), int'(cap_q[i].r), 16'h2000 + i);
    end

    // No producer: underrun on every load, DOUT silent.
    do_reset(2);
    urc = 0; ones1 = 0;
    while (cyc < FIRST + 2 * FRAME + 20) begin
      step();
      if (underrun === 1'b1) urc++;
      if (I2S_DOUT === 1'b1) ones1++;
    end
    check("underrun_pulses", urc, 3);
    check("silent_dout", ones1, 0);

    // One pair 7FFF/8000, then starvation.
    do_reset(2);
    push_at(2, 16'h7FFF, 16'h8000);
    ones1 = 0; ones2 = 0;
    while (cyc < FIRST + 2 * FRAME) begin
      step();
      if (cyc >= FIRST && cyc < FIRST + FRAME && I2S_DOUT === 1'b1) ones1++;
      if (cyc >= FIRST + FRAME && I2S_DOUT === 1'b1) ones2++;
    end
    check("starve_frame1_ones", ones1, 16 * 2 * H);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    check("starve_frame2_ones", ones2, 16 * 2 * H);
`else
    check("starve_frame2_ones", ones2, 0);
`endif

    // Push on the load cycle with one pair queued.
    do_reset(2);
    push_at(2, 16'h1111, 16'h2222);
    push_at(3, 16'h3333, 16'h4444);
    push_at(FIRST + FRAME, 16'h5555, 16'h6666);
    check("ready_on_load_push", int'(sample_ready), 1);
    step();
    check("ready_after_load_push", int'(sample_ready), 1);
    run_to(FIRST + 3 * FRAME - 2);
    check("order_frames", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      check("order_l0", int'(cap_q[0].l), 16'h1111);
      check("order_l1", int'(cap_q[1].l), 16'h3333);
      check("order_r2", int'(cap_q[2].r), 16'h6666);
    end

    // Random traffic, then a 1-cycle reset at bit_cnt 40, then more random traffic.
    do_reset(2);
    while (cyc < FIRST + FRAME + 40 * 2 * H + 5) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_l = W'($urandom); sample_r = W'($urandom);
      step();
    end
    sample_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_vec("midreset_outputs", dut_out(), 6'b000000);
    run_to(FIRST - 1);
    check("midreset_no_early_load", int'(frame_start), 0);
    step();
    check("midreset_load_at_16", int'(frame_start), 1);
    check("midreset_fifo_flushed", int'(underrun), 1);
    while (cyc < FIRST + 3 * FRAME) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_l = W'($urandom); sample_r = W'($urandom);
      step();
    end
    sample_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
